cmd_read: RTL and testbench

CMD_READ -- requirements
Module: cmd_read

---
 rtl/cmd_read_if.sv | 30 +++
 rtl/cmd_read.sv | 132 +++++++++++++
 tb/tb_cmd_read.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_read_if.sv
// Signal bundle between the SD host command path and the CMD response receiver.
interface cmd_read_if;
  logic         clk_en_p_i;
  logic         cmd_i;
  logic         start_listen_i;
  logic         abort_i;
  logic         long_rsp_i;
  logic         crc_check_en_i;
  logic         idx_check_en_i;
  logic [5:0]   exp_idx_i;
  logic [119:0] rsp_o;
  logic         busy_o;
  logic         done_o;
  logic         timeout_err_o;
  logic         crc_err_o;
  logic         end_bit_err_o;
  logic         idx_err_o;

  modport slave (
    input  clk_en_p_i, cmd_i, start_listen_i, abort_i, long_rsp_i,
           crc_check_en_i, idx_check_en_i, exp_idx_i,
    output rsp_o, busy_o, done_o, timeout_err_o, crc_err_o, end_bit_err_o, idx_err_o
  );

  modport master (
    output clk_en_p_i, cmd_i, start_listen_i, abort_i, long_rsp_i,
           crc_check_en_i, idx_check_en_i, exp_idx_i,
    input  rsp_o, busy_o, done_o, timeout_err_o, crc_err_o, end_bit_err_o, idx_err_o
  );
endinterface

// File: rtl/cmd_read.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48- or
// 136-bit response, checks CRC7 / end bit / command index and reports once.
module cmd_read (
  input  logic       clk_i,
  input  logic       rst_ni,
  cmd_read_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_RECEIVE, S_DONE} state_t;

  state_t         state_q;
  logic [5:0]     wait_cnt_q;
  logic [7:0]     bit_cnt_q;
  logic [6:0]     crc_q;
  logic [127:0]   sh_q;
  logic           long_q, crc_en_q, idx_en_q;
  logic [5:0]     exp_idx_q;
  logic [119:0]   rsp_q;
  logic           done_q, tout_q, crc_err_q, end_err_q, idx_err_q;

  logic [127:0]   sh_d;
  logic [6:0]     crc_d;
  logic [7:0]     last_bit_d;
  logic           crc_upd_d;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // Next shift/CRC values and which received bits fall inside the CRC window.
  // The start bit is never fed in: with a zero seed a leading 0 leaves CRC7 at 0.
  // Only the last 128 bits are kept, enough for bits 127:0 of a long frame.
  always_comb begin
    sh_d       = {sh_q[126:0], bus.cmd_i};
    crc_d      = crc7_step(crc_q, bus.cmd_i);
    last_bit_d = long_q ? 8'd134 : 8'd46;
    crc_upd_d  = 1'b0;
    if (long_q) crc_upd_d = (bit_cnt_q >= 8'd7) && (bit_cnt_q <= 8'd126);
    else        crc_upd_d = (bit_cnt_q <= 8'd38);
  end

  // Receiver FSM with registered results; abort overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      crc_q      <= '0;
      sh_q       <= '0;
      long_q     <= 1'b0;
      crc_en_q   <= 1'b0;
      idx_en_q   <= 1'b0;
      exp_idx_q  <= '0;
      rsp_q      <= '0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      idx_err_q  <= 1'b0;
    end else if (bus.abort_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_listen_i) begin
            long_q     <= bus.long_rsp_i;
            crc_en_q   <= bus.crc_check_en_i;
            idx_en_q   <= bus.idx_check_en_i;
            exp_idx_q  <= bus.exp_idx_i;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            crc_q      <= '0;
            sh_q       <= '0;
            rsp_q      <= '0;
            tout_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            idx_err_q  <= 1'b0;
            state_q    <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (bus.clk_en_p_i) begin
            if (!bus.cmd_i) begin
              state_q <= S_RECEIVE;
            end else if (wait_cnt_q == 6'd63) begin
              tout_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              wait_cnt_q <= wait_cnt_q + 6'd1;
            end
          end
        end
        S_RECEIVE: begin
          if (bus.clk_en_p_i) begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_q + 8'd1;
            if (crc_upd_d) crc_q <= crc_d;
            if (bit_cnt_q == last_bit_d) begin
              rsp_q     <= long_q ? sh_d[127:8] : {88'd0, sh_d[39:8]};
              end_err_q <= ~bus.cmd_i;
              crc_err_q <= crc_en_q & (crc_q != sh_d[7:1]);
              idx_err_q <= idx_en_q & ~long_q & (sh_d[45:40] != exp_idx_q);
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_o         = rsp_q;
  assign bus.busy_o        = (state_q == S_WAIT_START) || (state_q == S_RECEIVE);
  assign bus.done_o        = done_q;
  assign bus.timeout_err_o = tout_q;
  assign bus.crc_err_o     = crc_err_q;
  assign bus.end_bit_err_o = end_err_q;
  assign bus.idx_err_o     = idx_err_q;

endmodule

// File: tb/tb_cmd_read.sv
// Bench for cmd_read: table of response frames (fixed and random) scored
// against a frame-level reference, plus timeout, abort and reset sequences.
module tb_cmd_read;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_read_if bus ();
  cmd_read dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic         lng, cen, ien;
    logic [5:0]   xidx;
    logic [135:0] fr;
    int           pre;
    logic [119:0] e_rsp;
    logic         e_crc, e_end, e_idx;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  vec_t tbl[$];

  localparam logic [119:0] PAY = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.done_o === 1'b1) done_cnt++;
  endtask

  task automatic strobe(input logic b);
    repeat ($urandom_range(0, 2)) tick();
    bus.clk_en_p_i = 1'b1;
    bus.cmd_i      = b;
    tick();
    bus.clk_en_p_i = 1'b0;
    bus.cmd_i      = 1'($urandom);
  endtask

  task automatic arm(input logic lng, input logic cen, input logic ien, input logic [5:0] xidx);
    bus.start_listen_i = 1'b1;
    bus.long_rsp_i     = lng;
    bus.crc_check_en_i = cen;
    bus.idx_check_en_i = ien;
    bus.exp_idx_i      = xidx;
    tick();
    bus.start_listen_i = 1'b0;
    bus.long_rsp_i     = 1'($urandom);
    bus.crc_check_en_i = 1'($urandom);
    bus.idx_check_en_i = 1'($urandom);
    bus.exp_idx_i      = 6'($urandom);
  endtask

  // CRC7 as polynomial long division of frame bits hi..8 (times x^7) by 0x89.
  function automatic logic [6:0] crc_ref(input logic [135:0] fr, input int hi);
    logic [7:0] r;
    r = '0;
    for (int i = hi; i >= 1; i--) begin
      r = {r[6:0], (i >= 8) ? fr[i] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Expected results of one frame from the response format rules.
  function automatic vec_t model(input vec_t v);
    vec_t o;
    o = v;
    if (v.lng) begin
      o.e_rsp = v.fr[127:8];
      o.e_crc = v.cen && (crc_ref(v.fr, 127) != v.fr[7:1]);
      o.e_idx = 1'b0;
    end else begin
      o.e_rsp = {88'd0, v.fr[39:8]};
      o.e_crc = v.cen && (crc_ref(v.fr, 47) != v.fr[7:1]);
      o.e_idx = v.ien && (v.fr[45:40] != v.xidx);
    end
    o.e_end = (v.fr[0] == 1'b0);
    return o;
  endfunction

  function automatic vec_t mk(input logic lng, input logic cen, input logic ien,
                              input logic [5:0] xidx, input logic [135:0] fr, input int pre,
                              input logic [119:0] e_rsp, input logic e_crc,
                              input logic e_end, input logic e_idx);
    vec_t v;
    v.lng = lng; v.cen = cen; v.ien = ien; v.xidx = xidx; v.fr = fr; v.pre = pre;
    v.e_rsp = e_rsp; v.e_crc = e_crc; v.e_end = e_end; v.e_idx = e_idx;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int d0;
    int n;
    arm(v.lng, v.cen, v.ien, v.xidx);
    repeat (v.pre) strobe(1'b1);
    d0 = done_cnt;
    n  = v.lng ? 136 : 48;
    for (int i = n - 1; i >= 0; i--) begin
      if (i == n - 11) begin
        // re-arm attempt mid-frame with a different configuration
        bus.start_listen_i = 1'b1;
        bus.long_rsp_i     = ~v.lng;
        bus.crc_check_en_i = ~v.cen;
        bus.exp_idx_i      = ~v.xidx;
        tick();
        bus.start_listen_i = 1'b0;
      end
      strobe(v.fr[i]);
      if (i == 1) chk({tag, ".early_done"}, 120'(done_cnt - d0), 120'd0);
    end
    chk({tag, ".done"}, 120'(done_cnt - d0), 120'd1);
    tick();
    strobe(1'b0);
    strobe(1'b1);
    chk({tag, ".done_once"}, 120'(done_cnt - d0), 120'd1);
    chk({tag, ".busy"},  120'(bus.busy_o), 120'd0);
    chk({tag, ".rsp"},   bus.rsp_o, v.e_rsp);
    chk({tag, ".crc"},   120'(bus.crc_err_o), 120'(v.e_crc));
    chk({tag, ".end"},   120'(bus.end_bit_err_o), 120'(v.e_end));
    chk({tag, ".idx"},   120'(bus.idx_err_o), 120'(v.e_idx));
    chk({tag, ".tout"},  120'(bus.timeout_err_o), 120'd0);
  endtask

  initial begin
    logic [135:0] f31, f32, f31e, flong, fr;
    vec_t v;
    int   d0;

    bus.clk_en_p_i = 0; bus.cmd_i = 1; bus.start_listen_i = 0; bus.abort_i = 0;
    bus.long_rsp_i = 0; bus.crc_check_en_i = 0; bus.idx_check_en_i = 0; bus.exp_idx_i = 0;

    // reset state
    repeat (3) tick();
    chk("rst.rsp",  bus.rsp_o, 120'd0);
    chk("rst.busy", 120'(bus.busy_o), 120'd0);
    chk("rst.done", 120'(bus.done_o), 120'd0);
    chk("rst.flags", 120'({bus.timeout_err_o, bus.crc_err_o, bus.end_bit_err_o, bus.idx_err_o}), 120'd0);
    rst_n = 1'b1;
    tick();

    // fixed frames
    f31   = {88'd0, 48'h11_00000900_67};
    f32   = {88'd0, 48'h11_00000901_67};
    f31e  = {88'd0, 48'h11_00000900_66};
    flong = {8'h3F, PAY, 8'h00};
    flong[7:1] = crc_ref(flong, 127);
    tbl.push_back(mk(0, 1, 1, 6'd17, f31, 4, 120'h900, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6'd17, f32, 4, 120'h901, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6'd12, f31, 4, 120'h900, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 6'd12, f31, 4, 120'h900, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6'd17, f31, 63, 120'h900, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6'd17, f31e, 0, 120'h900, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 6'd17, f32, 0, 120'h901, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 6'd5, flong, 2, PAY, 0, 1, 0));

    // random frames, expectations from the reference
    for (int k = 0; k < 14; k++) begin
      fr = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
      v.lng = ($urandom_range(0, 2) == 0);
      v.cen = 1'($urandom);
      v.ien = 1'($urandom);
      v.pre = $urandom_range(0, 63);
      if (v.lng) fr[135] = 1'b0;
      else begin
        fr[135:48] = '0;
        fr[47] = 1'b0;
      end
      v.xidx = $urandom_range(0, 1) ? fr[45:40] : 6'($urandom);
      if ($urandom_range(0, 1)) fr[7:1] = crc_ref(fr, v.lng ? 127 : 47);
      fr[0] = ($urandom_range(0, 3) != 0);
      v.fr = fr;
      tbl.push_back(model(v));
    end

    foreach (tbl[k]) run_vec(tbl[k], $sformatf("v%0d", k));

    // timeout: 64 samples of 1
    arm(0, 1, 1, 6'd17);
    d0 = done_cnt;
    repeat (63) strobe(1'b1);
    chk("tout.early_done", 120'(done_cnt - d0), 120'd0);
    chk("tout.busy", 120'(bus.busy_o), 120'd1);
    strobe(1'b1);
    chk("tout.done", 120'(done_cnt - d0), 120'd1);
    chk("tout.flag", 120'(bus.timeout_err_o), 120'd1);
    chk("tout.rsp", bus.rsp_o, 120'd0);
    chk("tout.other", 120'({bus.crc_err_o, bus.end_bit_err_o, bus.idx_err_o}), 120'd0);
    tick();
    chk("tout.idle", 120'(bus.busy_o), 120'd0);

    // abort at bit 20 of RECEIVE, then immediate re-arm
    arm(0, 1, 1, 6'd17);
    d0 = done_cnt;
    strobe(1'b1);
    strobe(1'b0);
    for (int i = 0; i < 20; i++) strobe(1'($urandom));
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort.busy", 120'(bus.busy_o), 120'd0);
    repeat (30) strobe(1'($urandom));
    chk("abort.no_done", 120'(done_cnt - d0), 120'd0);
    chk("abort.flags", 120'({bus.timeout_err_o, bus.crc_err_o, bus.end_bit_err_o, bus.idx_err_o}), 120'd0);
    run_vec(tbl[0], "rearm");

    // abort and start together in IDLE
    d0 = done_cnt;
    bus.abort_i = 1'b1;
    bus.start_listen_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    bus.start_listen_i = 1'b0;
    chk("abst.busy", 120'(bus.busy_o), 120'd0);
    repeat (70) strobe(1'b1);
    chk("abst.no_done", 120'(done_cnt - d0), 120'd0);

    // reset during RECEIVE
    arm(0, 1, 1, 6'd17);
    strobe(1'b0);
    for (int i = 0; i < 10; i++) strobe(1'($urandom));
    rst_n = 1'b0;
    #1;
    chk("rrst.busy", 120'(bus.busy_o), 120'd0);
    chk("rrst.rsp", bus.rsp_o, 120'd0);
    tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (60) strobe(1'($urandom));
    chk("rrst.no_done", 120'(done_cnt - d0), 120'd0);
    chk("rrst.idle", 120'(bus.busy_o), 120'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
